z3_slave_ctrl: RTL and testbench
================================

# z3_slave_ctrl

Parametrised Zorro III slave-cycle controller: the next-generation bus front end for our expansion boards. It decodes up to NUM_WIN address windows, runs the slave/DTACK handshake, and adds multiple-transfer (burst) support with MTACK_n. It hands each data phase to a backend (SDRAM, autoconfig, I/O) through a request/acknowledge pair. The block is fully synchronous to CLK.

## Interface
- NUM_WIN, 2: number of address windows (1..4).
- MATCH_BITS, 8: width of the compared high address field, A[31:32-MATCH_BITS].
- SYNC_STAGES, 2: synchronizer depth on FCS_n, DS_n and MTCR_n (≥2).
- TIMEOUT_CYCLES, 255: watchdog limit in the DATA state, used only with Z3_TIMEOUT_EN.

Ports:
- CLK  in  1  bus clock; every register is on its rising edge.
- RST  in  1  reset, synchronous and active-high.
- FCS_n  in  1  Zorro III full cycle strobe (asynchronous).
- DS_n  in  4  data strobes (asynchronous).
- MTCR_n  in  1  multiple-transfer cycle strobe (asynchronous).
- DOE  in  1  data output enable.
- READ  in  1  1 = read cycle.
- FC  in  3  function code.
- A_HI  in  MATCH_BITS  high address bits, stable while FCS_n is low.
- win_base  in  NUM_WIN*MATCH_BITS  base address per window; window i occupies slice i.
- win_en  in  NUM_WIN  per-window enable.
- win_burst  in  NUM_WIN  per-window permission to grant MTACK.
- cycle_ack  in  1  backend has completed the current data phase.
- slave  out  1  registered SLAVE assertion (active-high; the pad inverts it).
- dtack  out  1  DTACK assertion.
- mtack  out  1  MTACK assertion.
- cycle_req  out  1  data phase request to the backend.
- cycle_win  out  2  index of the matched window.
- cycle_rw  out  1  latched READ.
- cycle_ds  out  4  active-high synchronized strobes.
- burst_cnt  out  8  number of data phases in the current cycle, saturating at 255.
- timeout  out  1  one-cycle pulse on watchdog abort.

## Operation
- **Synchronizers.** FCS_n, DS_n and MTCR_n each pass through SYNC_STAGES flops. The synchronized versions are named fcs, ds[3:0] and mtcr, all active-high.
- **Address decode.** Decode happens in IDLE on the first cycle fcs is seen asserted.
  - A window i hits when win_en[i] is set and A_HI equals the win_base slice for i.
  - The access must also be in a valid space: FC[1]^FC[0] = 1.
  - If several windows hit, the lowest index wins.
  - On a hit, the block latches cycle_win, cycle_rw and the burst grant (win_burst of the winner).
- **States.** IDLE, START, DATA, ACK, MT_WAIT.
  - IDLE → START on fcs & hit. slave goes to 1 and burst_cnt is cleared. If fcs is asserted with no hit, the block stays in IDLE until fcs is released.
  - START → DATA when any ds is asserted and DOE is high. cycle_req goes to 1. In START, mtack is driven from mtcr & grant.
  - DATA → ACK on cycle_ack. cycle_req goes to 0, dtack goes to 1 and burst_cnt increments (saturating).
  - ACK → MT_WAIT when all ds are released, fcs is still asserted and mtack is set. dtack goes to 0.
  - ACK → IDLE when fcs is released.
  - MT_WAIT → DATA when any ds is asserted and DOE is high. cycle_req goes to 1 and cycle_ds is reloaded.
  - MT_WAIT → IDLE when fcs is released.
- **fcs release.** Release of fcs in any state returns the block to IDLE on the next edge. slave, dtack, mtack and cycle_req all clear together.
- **cycle_ds.** Tracks ds while in DATA.
- **Reset.** All outputs are 0 and the state is IDLE. Reset asserted in the middle of a cycle aborts it on that edge; no request is left pending.

## Timing
- From FCS_n falling to slave high: SYNC_STAGES + 1 cycles.
- From strobe asserted to cycle_req high: SYNC_STAGES + 1 cycles.
- From cycle_ack sampled high to dtack high: 1 cycle. dtack holds until the strobes or fcs are released.
- cycle_req is a level. The backend must not pulse cycle_ack while cycle_req is low; a cycle_ack outside DATA is ignored.
- cycle_ack arriving on the same edge that fcs is released: the release wins. The block enters IDLE, and burst_cnt is not incremented.
- mtack changes only in START. It stays held through the rest of the cycle until fcs is released.

## Configuration
- **Z3_TIMEOUT_EN defined:** an 8-bit counter runs in DATA.
  - If cycle_ack has not arrived after TIMEOUT_CYCLES cycles, the block pulses timeout for 1 cycle, drops cycle_req and enters ACK with dtack = 1, so the host is not hung.
  - The counter clears on every entry to DATA.
- **Z3_TIMEOUT_EN undefined:** there is no counter, timeout is tied to 0, and DATA waits for cycle_ack indefinitely.

## Test plan
- **Single read.** Window 0 base = 8'h40, A_HI = 8'h40, FC = 3'b001, READ = 1. Assert FCS_n, then DS_n = 4'h0, then cycle_ack 3 cycles later. Required: slave, then cycle_req, then dtack; cycle_win = 0; burst_cnt = 1; all outputs clear 1 cycle after fcs is released.
- **Miss and priority.** A_HI = 8'h41 with both windows at 8'h40/8'h41 and win_en = 2'b11: cycle_win = 1. Then FC = 3'b111: slave stays 0 for the whole cycle.
- **Burst.** win_burst[0] = 1 and MTCR_n asserted in START: mtack = 1. Four DS pulses, each acked: four DATA/ACK passes through MT_WAIT, burst_cnt = 4. With win_burst[0] = 0: mtack = 0 and the cycle ends after 1 phase.
- **Abort.** Release FCS_n in DATA before cycle_ack: IDLE next edge, cycle_req = 0, dtack never asserts. Repeat with RST asserted in ACK: all outputs are 0 on the next edge.
- **Timeout (Z3_TIMEOUT_EN, TIMEOUT_CYCLES = 16).** No cycle_ack: timeout pulses 16 cycles after DATA entry and dtack = 1. Without the macro, dtack stays 0 after 300 cycles.

Source files
------------

// File: rtl/z3_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : z3_slave_ctrl
// Description : Zorro III slave-cycle controller. Synchronizes the bus
//               strobes, decodes up to NUM_WIN address windows, runs the
//               SLAVE/DTACK handshake with multiple-transfer (MTACK) bursts
//               and hands every data phase to a backend via cycle_req /
//               cycle_ack.
//               Optional feature macro: Z3_TIMEOUT_EN (DATA-state watchdog).
// Revision    : 1.0 - initial release
// ============================================================================
module z3_slave_ctrl #(
    parameter int NUM_WIN        = 2,
    parameter int MATCH_BITS     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          FCS_n,
    input  logic [3:0]                    DS_n,
    input  logic                          MTCR_n,
    input  logic                          DOE,
    input  logic                          READ,
    input  logic [2:0]                    FC,
    input  logic [MATCH_BITS-1:0]         A_HI,
    input  logic [NUM_WIN*MATCH_BITS-1:0] win_base,
    input  logic [NUM_WIN-1:0]            win_en,
    input  logic [NUM_WIN-1:0]            win_burst,
    input  logic                          cycle_ack,
    output logic                          slave,
    output logic                          dtack,
    output logic                          mtack,
    output logic                          cycle_req,
    output logic [1:0]                    cycle_win,
    output logic                          cycle_rw,
    output logic [3:0]                    cycle_ds,
    output logic [7:0]                    burst_cnt,
    output logic                          timeout
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_ACK     = 3'd3,
        ST_MT_WAIT = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizers (active-low chains, reset to the released level)
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0]      fcs_n_sync_q;
    logic [SYNC_STAGES-1:0]      mtcr_n_sync_q;
    logic [SYNC_STAGES-1:0][3:0] ds_n_sync_q;

    logic       w_fcs;
    logic       w_mtcr;
    logic [3:0] w_ds;

    // Shift the asynchronous strobes through SYNC_STAGES flops each
    always_ff @(posedge CLK) begin
        if (RST) begin
            fcs_n_sync_q  <= '1;
            mtcr_n_sync_q <= '1;
            ds_n_sync_q   <= '1;
        end else begin
            fcs_n_sync_q  <= {fcs_n_sync_q[SYNC_STAGES-2:0], FCS_n};
            mtcr_n_sync_q <= {mtcr_n_sync_q[SYNC_STAGES-2:0], MTCR_n};
            ds_n_sync_q   <= {ds_n_sync_q[SYNC_STAGES-2:0], DS_n};
        end
    end

    assign w_fcs  = ~fcs_n_sync_q[SYNC_STAGES-1];
    assign w_mtcr = ~mtcr_n_sync_q[SYNC_STAGES-1];
    assign w_ds   = ~ds_n_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [NUM_WIN-1:0] w_win_hit;
    logic               w_hit_any;
    logic [1:0]         w_hit_idx;
    logic               w_hit_grant;
    logic               w_space_ok;
    logic               w_decode_hit;
    logic               w_fc2_unused;

    generate
        for (genvar gi = 0; gi < NUM_WIN; gi++) begin : g_win
            assign w_win_hit[gi] = win_en[gi] &&
                                   (A_HI == win_base[gi*MATCH_BITS +: MATCH_BITS]);
        end
    endgenerate

    // Priority select: scanning downwards leaves the lowest hitting index
    always_comb begin
        w_hit_any   = 1'b0;
        w_hit_idx   = 2'd0;
        w_hit_grant = 1'b0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (w_win_hit[i]) begin
                w_hit_any   = 1'b1;
                w_hit_idx   = 2'(i);
                w_hit_grant = win_burst[i];
            end
        end
    end

    // Only the two data/program spaces (FC = x01 / x10) are decoded
    assign w_space_ok   = FC[1] ^ FC[0];
    assign w_decode_hit = w_hit_any & w_space_ok;
    assign w_fc2_unused = FC[2];

    // ------------------------------------------------------------------
    // Cycle state machine with registered outputs
    // ------------------------------------------------------------------
    state_t     state_q;
    logic       miss_q;     // fcs seen with no hit: ignore until release
    logic       grant_q;    // burst permission of the decoded window
    logic       slave_q;
    logic       dtack_q;
    logic       mtack_q;
    logic       req_q;
    logic [1:0] win_q;
    logic       rw_q;
    logic [3:0] ds_q;
    logic [7:0] cnt_q;

`ifdef Z3_TIMEOUT_EN
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] timer_q;
    logic       timeout_q;
    assign timeout = timeout_q;
`else
    // No watchdog in this build; the limit parameter has no effect.
    localparam int c_TIMEOUT_unused = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // Sequence IDLE/START/DATA/ACK/MT_WAIT; fcs release overrides every state
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            miss_q  <= 1'b0;
            grant_q <= 1'b0;
            slave_q <= 1'b0;
            dtack_q <= 1'b0;
            mtack_q <= 1'b0;
            req_q   <= 1'b0;
            win_q   <= 2'd0;
            rw_q    <= 1'b0;
            ds_q    <= 4'd0;
            cnt_q   <= 8'd0;
`ifdef Z3_TIMEOUT_EN
            timer_q   <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef Z3_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            if (!w_fcs) begin
                // Bus released: drop the whole handshake at once. A
                // simultaneous cycle_ack is deliberately lost here.
                state_q <= ST_IDLE;
                miss_q  <= 1'b0;
                grant_q <= 1'b0;
                slave_q <= 1'b0;
                dtack_q <= 1'b0;
                mtack_q <= 1'b0;
                req_q   <= 1'b0;
                win_q   <= 2'd0;
                rw_q    <= 1'b0;
                ds_q    <= 4'd0;
                cnt_q   <= 8'd0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        // Decode exactly once per fcs assertion
                        if (!miss_q) begin
                            if (w_decode_hit) begin
                                state_q <= ST_START;
                                slave_q <= 1'b1;
                                cnt_q   <= 8'd0;
                                win_q   <= w_hit_idx;
                                rw_q    <= READ;
                                grant_q <= w_hit_grant;
                            end else begin
                                miss_q <= 1'b1;
                            end
                        end
                    end

                    ST_START: begin
                        // MTACK is only (re)evaluated here and then held
                        mtack_q <= w_mtcr & grant_q;
                        if ((|w_ds) && DOE) begin
                            state_q <= ST_DATA;
                            req_q   <= 1'b1;
                            ds_q    <= w_ds;
`ifdef Z3_TIMEOUT_EN
                            timer_q <= 8'd0;
`endif
                        end
                    end

                    ST_DATA: begin
                        ds_q <= w_ds;
                        if (cycle_ack) begin
                            state_q <= ST_ACK;
                            req_q   <= 1'b0;
                            dtack_q <= 1'b1;
                            cnt_q   <= (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                        end
`ifdef Z3_TIMEOUT_EN
                        else if (timer_q == c_TO_LAST) begin
                            // Backend is stuck: terminate so the host is released
                            state_q   <= ST_ACK;
                            req_q     <= 1'b0;
                            dtack_q   <= 1'b1;
                            timeout_q <= 1'b1;
                        end else begin
                            timer_q <= timer_q + 8'd1;
                        end
`endif
                    end

                    ST_ACK: begin
                        // DTACK holds until the strobes go away; only a
                        // granted burst may go on to another data phase.
                        if (w_ds == 4'd0) begin
                            dtack_q <= 1'b0;
                            if (mtack_q) begin
                                state_q <= ST_MT_WAIT;
                            end
                        end
                    end

                    ST_MT_WAIT: begin
                        if ((|w_ds) && DOE) begin
                            state_q <= ST_DATA;
                            req_q   <= 1'b1;
                            ds_q    <= w_ds;
`ifdef Z3_TIMEOUT_EN
                            timer_q <= 8'd0;
`endif
                        end
                    end

                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign slave     = slave_q;
    assign dtack     = dtack_q;
    assign mtack     = mtack_q;
    assign cycle_req = req_q;
    assign cycle_win = win_q;
    assign cycle_rw  = rw_q;
    assign cycle_ds  = ds_q;
    assign burst_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_z3_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_z3_slave_ctrl
// Description : Self-checking bench for z3_slave_ctrl. A driver issues bus
//               cycles and queues the expected responses; a monitor pops and
//               compares them whenever slave, cycle_req or dtack rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_z3_slave_ctrl;

    localparam int NW = 2;
    localparam int MB = 8;
    localparam int SS = 2;
    localparam int TO = 16;

    localparam int S_SLAVE = 0;
    localparam int S_REQ   = 1;
    localparam int S_DTACK = 2;
    localparam int S_TO    = 3;

    logic          CLK = 1'b0;
    logic          RST;
    logic          FCS_n;
    logic [3:0]    DS_n;
    logic          MTCR_n;
    logic          DOE;
    logic          READ;
    logic [2:0]    FC;
    logic [MB-1:0] A_HI;
    logic [NW*MB-1:0] win_base;
    logic [NW-1:0] win_en;
    logic [NW-1:0] win_burst;
    logic          cycle_ack;
    logic          slave;
    logic          dtack;
    logic          mtack;
    logic          cycle_req;
    logic [1:0]    cycle_win;
    logic          cycle_rw;
    logic [3:0]    cycle_ds;
    logic [7:0]    burst_cnt;
    logic          timeout;

    z3_slave_ctrl #(
        .NUM_WIN        (NW),
        .MATCH_BITS     (MB),
        .SYNC_STAGES    (SS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .FCS_n     (FCS_n),
        .DS_n      (DS_n),
        .MTCR_n    (MTCR_n),
        .DOE       (DOE),
        .READ      (READ),
        .FC        (FC),
        .A_HI      (A_HI),
        .win_base  (win_base),
        .win_en    (win_en),
        .win_burst (win_burst),
        .cycle_ack (cycle_ack),
        .slave     (slave),
        .dtack     (dtack),
        .mtack     (mtack),
        .cycle_req (cycle_req),
        .cycle_win (cycle_win),
        .cycle_rw  (cycle_rw),
        .cycle_ds  (cycle_ds),
        .burst_cnt (burst_cnt),
        .timeout   (timeout)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int to_pulses = 0;

    typedef struct { int win; logic rw; logic [3:0] ds; } req_exp_t;
    typedef struct { int cnt; logic mt; } ack_exp_t;

    int       slave_q[$];
    req_exp_t req_q[$];
    ack_exp_t ack_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    function automatic logic sel(input int which);
        case (which)
            S_SLAVE: return slave;
            S_REQ:   return cycle_req;
            S_DTACK: return dtack;
            default: return timeout;
        endcase
    endfunction

    // Count negedges until the chosen output reaches lvl; bound+1 on expiry
    task automatic wait_sig(input int which, input logic lvl, input int bound, output int k);
        k = 0;
        while (k <= bound) begin
            @(negedge CLK);
            k++;
            if (sel(which) === lvl) return;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Reference decode: valid space, enabled window, first matching index
    function automatic int ref_decode(input logic [7:0] a, input logic [2:0] fc);
        if (fc[1] == fc[0]) return -1;
        for (int i = 0; i < NW; i++) begin
            if (win_en[i] && (win_base[i*MB +: MB] == a)) return i;
        end
        return -1;
    endfunction

    // Monitor: pop and compare whenever an output presents a new event
    logic p_slave = 1'b0, p_req = 1'b0, p_dtack = 1'b0, p_to = 1'b0;
    always @(negedge CLK) begin
        int       w;
        req_exp_t re;
        ack_exp_t ae;
        if (slave && !p_slave) begin
            chk("slave_pending", slave_q.size() != 0, 1'b1);
            if (slave_q.size() != 0) begin
                w = slave_q.pop_front();
                chk("slave_win", cycle_win, w);
            end
        end
        if (cycle_req && !p_req) begin
            chk("req_pending", req_q.size() != 0, 1'b1);
            if (req_q.size() != 0) begin
                re = req_q.pop_front();
                chk("req_win", cycle_win, re.win);
                chk("req_rw", cycle_rw, re.rw);
                chk("req_ds", cycle_ds, re.ds);
            end
        end
        if (dtack && !p_dtack) begin
            chk("ack_pending", ack_q.size() != 0, 1'b1);
            if (ack_q.size() != 0) begin
                ae = ack_q.pop_front();
                chk("ack_burst_cnt", burst_cnt, ae.cnt);
                chk("ack_mtack", mtack, ae.mt);
            end
        end
        if (timeout && !p_to) to_pulses++;
        p_slave = slave;
        p_req   = cycle_req;
        p_dtack = dtack;
        p_to    = timeout;
    end

    task automatic end_cycle();
        int k;
        FCS_n  = 1'b1;
        DS_n   = 4'hF;
        MTCR_n = 1'b1;
        DOE    = 1'b0;
        wait_sig(S_SLAVE, 1'b0, 10, k);
        chk("release_lat", k, SS + 1);
        chk("release_outs", {slave, dtack, mtack, cycle_req, cycle_win, cycle_rw,
                             cycle_ds, burst_cnt, timeout}, 0);
        tick(2);
    endtask

    task automatic run_cycle(input logic [7:0] a, input logic [2:0] fc, input logic rd,
                             input int nph, input logic use_mt, input int ackdly,
                             input logic abort_last, input logic doe_late);
        int         idx;
        int         k;
        logic       mt;
        logic       counts;
        logic [3:0] m;
        idx = ref_decode(a, fc);
        @(negedge CLK);
        A_HI   = a;
        FC     = fc;
        READ   = rd;
        MTCR_n = ~use_mt;
        FCS_n  = 1'b0;
        if (idx < 0) begin
            tick(6);
            chk("miss_slave", slave, 1'b0);
            FCS_n  = 1'b1;
            MTCR_n = 1'b1;
            tick(4);
            return;
        end
        mt = use_mt & win_burst[idx];
        slave_q.push_back(idx);
        wait_sig(S_SLAVE, 1'b1, 10, k);
        chk("slave_lat", k, SS + 1);
        for (int p = 0; p < nph; p++) begin
            counts = (p == 0) || mt;
            m      = 4'($urandom_range(1, 15));
            DOE    = ~doe_late;
            DS_n   = ~m;
            if (counts) req_q.push_back('{idx, rd, m});
            if (doe_late) begin
                tick(5);
                DOE = 1'b1;
            end
            if (!counts) begin
                tick(5);
                chk("no_req_after_single", cycle_req, 1'b0);
                DS_n = 4'hF;
                tick(4);
                continue;
            end
            wait_sig(S_REQ, 1'b1, 10, k);
            chk("req_lat", k, doe_late ? 1 : SS + 1);
            tick(ackdly);
            if (abort_last && (p == nph - 1)) begin
                FCS_n  = 1'b1;
                DS_n   = 4'hF;
                MTCR_n = 1'b1;
                DOE    = 1'b0;
                wait_sig(S_REQ, 1'b0, 10, k);
                chk("abort_lat", k, SS + 1);
                chk("abort_dtack", dtack, 1'b0);
                tick(3);
                return;
            end
            ack_q.push_back('{(p + 1 > 255) ? 255 : p + 1, mt});
            cycle_ack = 1'b1;
            wait_sig(S_DTACK, 1'b1, 4, k);
            cycle_ack = 1'b0;
            chk("dtack_lat", k, 1);
            DS_n = 4'hF;
            wait_sig(S_DTACK, 1'b0, 10, k);
            chk("dtack_release_lat", k, SS + 1);
            // Stray acknowledge outside DATA must be ignored
            cycle_ack = 1'b1;
            tick(1);
            cycle_ack = 1'b0;
        end
        end_cycle();
    endtask

    task automatic reset_in_ack();
        int k;
        @(negedge CLK);
        A_HI   = 8'h40;
        FC     = 3'b001;
        READ   = 1'b0;
        MTCR_n = 1'b1;
        FCS_n  = 1'b0;
        slave_q.push_back(0);
        wait_sig(S_SLAVE, 1'b1, 10, k);
        DS_n = 4'h0;
        DOE  = 1'b1;
        req_q.push_back('{0, 1'b0, 4'hF});
        wait_sig(S_REQ, 1'b1, 10, k);
        ack_q.push_back('{1, 1'b0});
        cycle_ack = 1'b1;
        wait_sig(S_DTACK, 1'b1, 4, k);
        cycle_ack = 1'b0;
        chk("rst_pre_dtack", dtack, 1'b1);
        RST = 1'b1;
        tick(1);
        chk("rst_outs", {slave, dtack, mtack, cycle_req, cycle_win, cycle_rw,
                         cycle_ds, burst_cnt, timeout}, 0);
        FCS_n = 1'b1;
        DS_n  = 4'hF;
        DOE   = 1'b0;
        RST   = 1'b0;
        tick(4);
        chk("rst_after_slave", slave, 1'b0);
    endtask

    task automatic timeout_test();
        int k;
        @(negedge CLK);
        A_HI   = 8'h40;
        FC     = 3'b010;
        READ   = 1'b1;
        MTCR_n = 1'b1;
        FCS_n  = 1'b0;
        slave_q.push_back(0);
        wait_sig(S_SLAVE, 1'b1, 10, k);
        DS_n = 4'h3;
        DOE  = 1'b1;
        req_q.push_back('{0, 1'b1, 4'hC});
        wait_sig(S_REQ, 1'b1, 10, k);
`ifdef Z3_TIMEOUT_EN
        ack_q.push_back('{0, 1'b0});
        wait_sig(S_TO, 1'b1, 40, k);
        chk("timeout_lat", k, TO);
        chk("timeout_dtack", dtack, 1'b1);
        chk("timeout_req", cycle_req, 1'b0);
`else
        tick(300);
        chk("no_timeout_dtack", dtack, 1'b0);
        chk("no_timeout_req", cycle_req, 1'b1);
`endif
        end_cycle();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got expired, wanted completion");
        $fatal(1, "time limit");
    end

    initial begin
        int         j;
        logic [7:0] a;
        logic [2:0] fc;
        RST = 1'b1;  FCS_n = 1'b1; DS_n = 4'hF; MTCR_n = 1'b1; DOE = 1'b0;
        READ = 1'b0; FC = 3'd0; A_HI = 8'd0; win_base = '0; win_en = '0;
        win_burst = '0; cycle_ack = 1'b0;
        tick(3);
        chk("reset_outs", {slave, dtack, mtack, cycle_req, cycle_win, cycle_rw,
                           cycle_ds, burst_cnt, timeout}, 0);
        RST = 1'b0;
        tick(2);

        // Single read on window 0, ack three cycles after the request
        win_base = {8'h41, 8'h40}; win_en = 2'b01; win_burst = 2'b00;
        run_cycle(8'h40, 3'b001, 1'b1, 1, 1'b0, 3, 1'b0, 1'b0);
        // Window 1 hit, priority among equal bases, invalid space
        win_en = 2'b11;
        run_cycle(8'h41, 3'b001, 1'b0, 1, 1'b0, 1, 1'b0, 1'b0);
        win_base = {8'h40, 8'h40};
        run_cycle(8'h40, 3'b110, 1'b1, 1, 1'b0, 0, 1'b0, 1'b0);
        win_base = {8'h41, 8'h40};
        run_cycle(8'h40, 3'b111, 1'b1, 1, 1'b0, 0, 1'b0, 1'b0);
        // Burst granted (4 phases) and refused (1 phase)
        win_burst = 2'b01;
        run_cycle(8'h40, 3'b001, 1'b1, 4, 1'b1, 0, 1'b0, 1'b0);
        win_burst = 2'b00;
        run_cycle(8'h40, 3'b001, 1'b1, 4, 1'b1, 0, 1'b0, 1'b0);
        // Abort in DATA, DOE gating, reset in ACK, watchdog
        run_cycle(8'h40, 3'b001, 1'b0, 1, 1'b0, 2, 1'b1, 1'b0);
        run_cycle(8'h41, 3'b101, 1'b0, 1, 1'b0, 1, 1'b0, 1'b1);
        reset_in_ack();
        timeout_test();

        // Randomized cycles
        for (int n = 0; n < 40; n++) begin
            win_base = 16'($urandom);
            if ($urandom_range(0, 3) == 0) win_base[15:8] = win_base[7:0];
            win_en    = 2'($urandom);
            win_burst = 2'($urandom);
            j = int'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 7) a = win_base[j*MB +: MB];
            else                          a = 8'($urandom);
            if ($urandom_range(0, 3) != 0) fc = {1'($urandom), 2'($urandom_range(1, 2))};
            else                           fc = 3'($urandom);
            run_cycle(a, fc, 1'($urandom), int'($urandom_range(1, 4)),
                      $urandom_range(0, 3) != 0, int'($urandom_range(0, 4)),
                      $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
        end

        tick(3);
        chk("slave_q_left", slave_q.size(), 0);
        chk("req_q_left", req_q.size(), 0);
        chk("ack_q_left", ack_q.size(), 0);
`ifdef Z3_TIMEOUT_EN
        chk("timeout_pulses", to_pulses, 1);
`else
        chk("timeout_pulses", to_pulses, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
